// File: rtl/metro_gate_ctrl_pkg.sv
// Shared types and default timing for the station gate cluster.
// State encodings are fixed so gate blocks and checkers agree on the debug view.
package metro_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_ALARM  = 2'd2
  } gate_state_e;

  localparam int DEF_TIMEOUT_CYCLES = 100;
  localparam int DEF_TIMER_W        = 32;
  localparam int DEF_CREDIT_W       = 3;
  localparam int DEF_PASS_W         = 16;
  localparam int DEF_ALARM_CYCLES   = 50;

endpackage

// File: rtl/metro_gate_ctrl_if.sv
// Fare/sensor/actuator bundle between the validator, passage sensor and gate controller.
// Handshake: valid_pay is a strobe, one fare per high cycle, with no ready; a fare that
// cannot be stored is dropped and reported by a one-cycle pay_reject pulse.
interface metro_gate_ctrl_if #(
  parameter int CREDIT_W = 3,
  parameter int PASS_W   = 16
);
  logic                valid_pay;
  logic                entry_flag;
  logic                unblock;
  logic [CREDIT_W-1:0] credits;
  logic [PASS_W-1:0]   pass_cnt;
  logic                pay_reject;
  logic                timeout_pulse;
  logic                alarm;

  modport master (
    output valid_pay, entry_flag,
    input  unblock, credits, pass_cnt, pay_reject, timeout_pulse, alarm
  );

  modport slave (
    input  valid_pay, entry_flag,
    output unblock, credits, pass_cnt, pay_reject, timeout_pulse, alarm
  );
endinterface

// File: rtl/metro_gate_ctrl_edge_det.sv
// Passage sensor register plus rising-edge detect; shared by the gate blocks.
module metro_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;
endmodule

// File: rtl/metro_gate_ctrl.sv
// Turnstile controller: buffers fares as credits, unlocks once per credit, relocks on timeout.
// Optional forced-entry alarm state is built only when METRO_ALARM_EN is defined.
module metro_gate_ctrl
  import metro_gate_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMER_W        = DEF_TIMER_W,
  parameter int CREDIT_W       = DEF_CREDIT_W,
  parameter int PASS_W         = DEF_PASS_W,
  parameter int ALARM_CYCLES   = DEF_ALARM_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  metro_gate_ctrl_if.slave  bus,
  output gate_state_e       state_dbg
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
  localparam logic [TIMER_W-1:0]  TO_LAST    = TIMER_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end
  if ((longint'(TIMEOUT_CYCLES) > (longint'(1) << TIMER_W)) ||
      (longint'(ALARM_CYCLES) > (longint'(1) << TIMER_W))) begin : g_bad_timer_w
    $error("TIMER_W too narrow for the configured timeouts");
  end

  gate_state_e         state_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [CREDIT_W-1:0] credits_q;
  logic [PASS_W-1:0]   pass_q;
  logic                unblock_q;
  logic                pay_reject_q;
  logic                timeout_q;

  logic entry_rise;
  logic full;
  logic want_fare;
  logic inc;
  logic dec;
  logic forced;

  metro_edge_det u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.entry_flag),
    .rise  (entry_rise)
  );

  assign full      = (credits_q == CREDIT_MAX);
  assign inc       = bus.valid_pay & ~full;
  // A payment in the same cycle counts as an available fare even with no stored credit.
  assign want_fare = (credits_q != '0) | bus.valid_pay;

`ifdef METRO_ALARM_EN
  logic                          alarm_q;
  localparam logic [TIMER_W-1:0] AL_LAST = TIMER_W'(ALARM_CYCLES - 1);
  assign forced    = entry_rise;
  assign bus.alarm = alarm_q;
`else
  assign forced    = 1'b0;
  assign bus.alarm = 1'b0;
`endif

  always_comb begin
    dec = 1'b0;
    case (state_q)
      ST_LOCKED: dec = want_fare & ~forced;
      ST_OPEN:   dec = entry_rise & want_fare;
      default:   dec = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOCKED;
      timer_q      <= '0;
      credits_q    <= '0;
      pass_q       <= '0;
      unblock_q    <= 1'b0;
      pay_reject_q <= 1'b0;
      timeout_q    <= 1'b0;
`ifdef METRO_ALARM_EN
      alarm_q      <= 1'b0;
`endif
    end else begin
      credits_q    <= credits_q + CREDIT_W'(inc) - CREDIT_W'(dec);
      pay_reject_q <= bus.valid_pay & full;
      timeout_q    <= 1'b0;
      case (state_q)
        ST_LOCKED: begin
          timer_q <= '0;
`ifdef METRO_ALARM_EN
          if (entry_rise) begin
            state_q <= ST_ALARM;
            alarm_q <= 1'b1;
          end else if (want_fare) begin
            state_q   <= ST_OPEN;
            unblock_q <= 1'b1;
          end
`else
          if (want_fare) begin
            state_q   <= ST_OPEN;
            unblock_q <= 1'b1;
          end
`endif
        end
        ST_OPEN: begin
          if (entry_rise) begin
            pass_q  <= pass_q + PASS_W'(1);
            timer_q <= '0;
            if (!want_fare) begin
              state_q   <= ST_LOCKED;
              unblock_q <= 1'b0;
            end
          end else if (timer_q == TO_LAST) begin
            // The fare that opened the gate is forfeited.
            state_q   <= ST_LOCKED;
            unblock_q <= 1'b0;
            timer_q   <= '0;
            timeout_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
`ifdef METRO_ALARM_EN
        ST_ALARM: begin
          if (entry_rise) begin
            timer_q <= '0;
          end else if (timer_q == AL_LAST) begin
            state_q <= ST_LOCKED;
            alarm_q <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
`endif
        default: begin
          state_q   <= ST_LOCKED;
          unblock_q <= 1'b0;
          timer_q   <= '0;
`ifdef METRO_ALARM_EN
          alarm_q   <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.unblock       = unblock_q;
  assign bus.credits       = credits_q;
  assign bus.pass_cnt      = pass_q;
  assign bus.pay_reject    = pay_reject_q;
  assign bus.timeout_pulse = timeout_q;
  assign state_dbg         = state_q;

endmodule
